mod_exp_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `mod_exp` engine between two requesters, such as the Schnorr signer and verifier paths. It holds the modulus configuration register and accepts one request at a time via valid/ready. It drives the engine's `start`/`base_in`/`exp_in`/`r`, captures `out` on `done`, and returns the result to the owning requester with a watchdog error flag.

---
 rtl/mod_exp_arbiter.sv | 151 +++++++++++++++
 tb/tb_mod_exp_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_arbiter.sv
// Round-robin front end sharing one mod_exp engine between two requesters.
// Holds the modulus register, sequences the engine and guards it with a watchdog.
module mod_exp_arbiter #(
    parameter int len     = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_we,
    input  logic [len-1:0] cfg_r,
    input  logic           req0_valid,
    input  logic           req1_valid,
    output logic           req0_ready,
    output logic           req1_ready,
    input  logic [len-1:0] req0_base,
    input  logic [len-1:0] req0_exp,
    input  logic [len-1:0] req1_base,
    input  logic [len-1:0] req1_exp,
    output logic           resp0_valid,
    output logic           resp1_valid,
    input  logic           resp0_ready,
    input  logic           resp1_ready,
    output logic [len-1:0] resp_data,
    output logic           resp_err,
    output logic           busy,
    output logic           me_start,
    output logic [len-1:0] me_base,
    output logic [len-1:0] me_exp,
    output logic [len-1:0] me_r,
    input  logic [len-1:0] me_out,
    input  logic           me_done
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic           r_ok;
    logic           r_last;
    logic           r_owner;
    logic [len-1:0] r_reg;
    logic [len-1:0] r_base;
    logic [len-1:0] r_exp;
    logic [len-1:0] r_data;
    logic           r_err;
    logic [CW-1:0]  r_cnt;

    logic w_gnt0;
    logic w_gnt1;
    logic w_timeout;
    logic w_resp_hs;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Tie goes to the requester that was not served last.
    always_comb begin
        w_next    = r_state;
        w_gnt0    = 1'b0;
        w_gnt1    = 1'b0;
        w_timeout = 1'b0;
        w_resp_hs = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_ok) begin
                    w_gnt0 = req0_valid && (!req1_valid || r_last);
                    w_gnt1 = req1_valid && (!req0_valid || !r_last);
                end
                if (w_gnt0 || w_gnt1) w_next = S_ISSUE;
            end
            S_ISSUE: w_next = S_BUSY;
            S_BUSY: begin
                if (me_done) begin
                    w_next = S_RESP;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_timeout = 1'b1;
                    w_next    = S_RESP;
                end
            end
            S_RESP: begin
                w_resp_hs = r_owner ? resp1_ready : resp0_ready;
                if (w_resp_hs) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ok    <= 1'b0;
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_reg   <= '0;
            r_base  <= '0;
            r_exp   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (r_state == S_IDLE && cfg_we) begin
                r_reg <= cfg_r;
                r_ok  <= 1'b1;
            end
            if (w_gnt0) begin
                r_base  <= req0_base;
                r_exp   <= req0_exp;
                r_owner <= 1'b0;
            end
            if (w_gnt1) begin
                r_base  <= req1_base;
                r_exp   <= req1_exp;
                r_owner <= 1'b1;
            end
            if (r_state == S_ISSUE) r_cnt <= '0;
            if (r_state == S_BUSY) begin
                if (me_done) begin
                    r_data <= me_out;
                    r_err  <= 1'b0;
                end else if (w_timeout) begin
                    r_data <= '0;
                    r_err  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_resp_hs) r_last <= r_owner;
        end
    end

    assign req0_ready  = w_gnt0;
    assign req1_ready  = w_gnt1;
    assign resp0_valid = (r_state == S_RESP) && !r_owner;
    assign resp1_valid = (r_state == S_RESP) && r_owner;
    assign resp_data   = r_data;
    assign resp_err    = r_err;
    assign busy        = (r_state != S_IDLE);
    assign me_start    = (r_state == S_ISSUE);
    assign me_base     = r_base;
    assign me_exp      = r_exp;
    assign me_r        = r_reg;

endmodule

// File: tb/tb_mod_exp_arbiter.sv
// Directed bench for mod_exp_arbiter with a behavioural engine stub
// and a response scoreboard.
module tb_mod_exp_arbiter;

    localparam int W   = 32;
    localparam int TO  = 16;
    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_we;
    logic [W-1:0] cfg_r;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_base, req0_exp, req1_base, req1_exp;
    logic         resp0_valid, resp1_valid;
    logic         resp0_ready, resp1_ready;
    logic [W-1:0] resp_data;
    logic         resp_err;
    logic         busy;
    logic         me_start;
    logic [W-1:0] me_base, me_exp, me_r;
    logic [W-1:0] me_out;
    logic         me_done;

    logic         eng_en;
    logic         eng_done;
    logic [W-1:0] eng_out;
    int           eng_cnt;
    logic         inj_done;
    logic [W-1:0] inj_out;

    int checks = 0;
    int failures = 0;
    int starts = 0;
    int exp_starts = 0;

    typedef struct {
        logic         owner;
        logic [W-1:0] data;
        logic         err;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    mod_exp_arbiter #(.len(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_r(cfg_r),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_base(req0_base), .req0_exp(req0_exp),
        .req1_base(req1_base), .req1_exp(req1_exp),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .busy(busy), .me_start(me_start),
        .me_base(me_base), .me_exp(me_exp), .me_r(me_r),
        .me_out(me_out), .me_done(me_done)
    );

    function automatic logic [W-1:0] modexp(input logic [W-1:0] b,
                                            input logic [W-1:0] e,
                                            input logic [W-1:0] m);
        logic [63:0] acc, bb, mm;
        if (m == '0) return '0;
        mm  = {32'b0, m};
        acc = 64'd1 % mm;
        bb  = {32'b0, b} % mm;
        for (int i = 0; i < W; i++) begin
            if (e[i]) acc = (acc * bb) % mm;
            bb = (bb * bb) % mm;
        end
        return acc[W-1:0];
    endfunction

    // Engine stub: fixed latency, result from the operands it was started with.
    always @(posedge clk) begin
        if (rst) begin
            eng_cnt  <= 0;
            eng_done <= 1'b0;
            eng_out  <= '0;
        end else begin
            eng_done <= 1'b0;
            if (me_start) begin
                eng_cnt <= LAT;
                eng_out <= modexp(me_base, me_exp, me_r);
            end else if (eng_cnt != 0) begin
                eng_cnt <= eng_cnt - 1;
                if (eng_cnt == 1 && eng_en) eng_done <= 1'b1;
            end
        end
    end

    assign me_done = eng_done | inj_done;
    assign me_out  = inj_done ? inj_out : eng_out;

    always @(posedge clk) if (me_start) starts <= starts + 1;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] ex);
        checks++;
        assert (obs === ex) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, ex);
        end
    endtask

    task automatic cfg_write(input logic [W-1:0] v);
        cfg_we = 1'b1;
        cfg_r  = v;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic accept(input int n, input logic [W-1:0] b,
                          input logic [W-1:0] e, input logic [W-1:0] ex_d,
                          input logic ex_e);
        logic got;
        got = 1'b0;
        if (n == 0) begin
            req0_base = b; req0_exp = e; req0_valid = 1'b1;
        end else begin
            req1_base = b; req1_exp = e; req1_valid = 1'b1;
        end
        for (int i = 0; i < 50; i++) begin
            #1;
            if ((n == 0) ? req0_ready : req1_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept_ready", got, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("start_pulse", me_start, 1);
        if (got) begin
            sbq.push_back('{n[0], ex_d, ex_e});
            exp_starts++;
        end
    endtask

    task automatic get_resp(output int waited);
        logic seen;
        exp_t e;
        seen   = 1'b0;
        waited = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (resp0_valid || resp1_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            waited++;
        end
        check("resp_seen", seen, 1);
        if (seen && sbq.size() > 0) begin
            e = sbq.pop_front();
            check("resp_owner", resp1_valid, e.owner);
            check("resp_one_hot", resp0_valid & resp1_valid, 0);
            check("resp_data", resp_data, e.data);
            check("resp_err", resp_err, e.err);
            if (e.owner) resp1_ready = 1'b1;
            else         resp0_ready = 1'b1;
            @(negedge clk);
            resp0_ready = 1'b0;
            resp1_ready = 1'b0;
            #1;
            check("resp_released", resp0_valid | resp1_valid, 0);
            check("idle_after_resp", busy, 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1);
    end

    initial begin
        int w;
        logic saw;
        exp_t ex;
        rst = 1'b1; cfg_we = 1'b0; cfg_r = '0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_base = '0; req0_exp = '0; req1_base = '0; req1_exp = '0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        eng_en = 1'b1; inj_done = 1'b0; inj_out = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_me_r", me_r, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_me_start", me_start, 0);
        check("rst_me_base", me_base, 0);

        // Requests before any modulus write must not be accepted.
        req0_base = 3; req0_exp = 5; req0_valid = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            saw = saw | req0_ready | req1_ready;
        end
        check("no_accept_before_cfg", saw, 0);
        @(negedge clk);
        cfg_we = 1'b1; cfg_r = 7;
        #1;
        check("no_accept_cfg_cycle", req0_ready, 0);
        @(negedge clk);
        cfg_we = 1'b0;
        accept(0, 3, 5, 5, 1'b0);
        check("me_r_7", me_r, 7);
        get_resp(w);
        check("one_start", starts, 1);

        // Tie after reset: requester 0 first.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cfg_write(1000);
        req0_base = 2; req0_exp = 10; req0_valid = 1'b1;
        req1_base = 5; req1_exp = 3;  req1_valid = 1'b1;
        #1;
        check("tie_req0_ready", req0_ready, 1);
        check("tie_req1_ready", req1_ready, 0);
        sbq.push_back('{1'b0, 32'd24, 1'b0});
        exp_starts++;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        get_resp(w);
        cfg_write(13);
        accept(1, 5, 3, 8, 1'b0);
        get_resp(w);

        // Both held valid: grants alternate 0,1,0,1.
        req0_base = 2; req0_exp = 10; req0_valid = 1'b1;
        req1_base = 5; req1_exp = 3;  req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            saw = 1'b0;
            for (int i = 0; i < 50; i++) begin
                #1;
                if (req0_ready || req1_ready) begin
                    saw = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("alt_grant_seen", saw, 1);
            check("alt_owner", req1_ready, k % 2);
            check("alt_one_hot", req0_ready & req1_ready, 0);
            ex.owner = k[0];
            ex.data  = k[0] ? modexp(5, 3, 13) : modexp(2, 10, 13);
            ex.err   = 1'b0;
            if (saw) begin
                sbq.push_back(ex);
                exp_starts++;
            end
            @(negedge clk);
            get_resp(w);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // exp=0 and a stalled consumer.
        cfg_write(7);
        accept(0, 3, 0, 1, 1'b0);
        for (int i = 0; i < 200 && !resp0_valid; i++) @(negedge clk);
        req1_base = 4; req1_exp = 2; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cfg_we = 1'b1; cfg_r = 99;
            #1;
            check("hold_valid", resp0_valid, 1);
            check("hold_data", resp_data, 1);
            check("hold_no_accept", req0_ready | req1_ready, 0);
            @(negedge clk);
        end
        cfg_we = 1'b0;
        req1_valid = 1'b0;
        #1;
        check("cfg_ignored", me_r, 7);
        get_resp(w);
        check("cfg_still_ignored", me_r, 7);

        // Watchdog: silent engine.
        eng_en = 1'b0;
        accept(0, 3, 5, 0, 1'b1);
        get_resp(w);
        check("timeout_latency", w, TO + 1);
        eng_en = 1'b1;
        accept(1, 3, 5, 5, 1'b0);
        get_resp(w);

        // Reset in BUSY drops the operation.
        accept(0, 3, 5, 5, 1'b0);
        @(negedge clk);
        #1;
        check("busy_before_rst", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sbq.delete();
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_me_r", me_r, 0);
        check("midrst_me_base", me_base, 0);
        check("midrst_me_exp", me_exp, 0);
        check("midrst_resp_valid", resp0_valid | resp1_valid, 0);
        check("midrst_resp_err", resp_err, 0);
        @(negedge clk);
        inj_out = 123; inj_done = 1'b1;
        req0_valid = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            saw = saw | resp0_valid | resp1_valid | busy | req0_ready;
            @(negedge clk);
        end
        check("late_done_ignored", saw, 0);
        req0_valid = 1'b0;
        check("start_count", starts, exp_starts);
        check("sb_empty", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
